// File: rtl/soc_sysid_pkg.sv
// Shared types and constants for the system-ID checker and the system-ID slave generator.
package soc_sysid_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WAIT_CNT_W = 16;

  localparam int unsigned SYSID_ID_OFS = 0;
  localparam int unsigned SYSID_TS_OFS = 1;

  localparam logic [DATA_W-1:0] SYSID_DEF_ID = 32'h0000_0000;
  localparam logic [DATA_W-1:0] SYSID_DEF_TS = 32'h635A_0997;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/soc_sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the system-ID slave.
interface soc_sysid_checker_if #(
  parameter int unsigned ADDR_W = 1
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              waitrequest;
  logic [31:0]       readdata;

  modport master (output address, read, input waitrequest, readdata);
  modport slave  (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/soc_wait_timer.sv
// Saturating stall counter with clear/enable; flags the cycle in which one more stall hits TIMEOUT.
module soc_wait_timer
  import soc_sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WAIT_CNT_W'(1);
    end
  end

  // A stall seen now with count at TIMEOUT-1 is the TIMEOUT-th consecutive stall.
  assign expire_c = (count >= WAIT_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/soc_sysid_checker.sv
// Boot-integrity check: reads the system-ID and timestamp words and publishes sticky pass/fail status.
module soc_sysid_checker
  import soc_sysid_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 1,
  parameter logic [31:0]       EXPECTED_ID = SYSID_DEF_ID,
  parameter logic [31:0]       EXPECTED_TS = SYSID_DEF_TS,
  parameter int unsigned       TIMEOUT     = 255,
  parameter bit                AUTO_START  = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  soc_sysid_checker_if.master  avm,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 id_err,
  output logic                 ts_err,
  output logic                 timeout_err,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              auto_q, auto_d;
  logic              busy_d, done_d, pass_d, id_err_d, ts_err_d, tout_d;
  logic [31:0]       id_d, ts_d;
  logic              tmr_clr, tmr_en, tmr_expire_c;

  soc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .expire_c (tmr_expire_c)
  );

  assign avm.address = addr_q;
  assign avm.read    = read_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      read_q      <= 1'b0;
      auto_q      <= AUTO_START;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_err      <= 1'b0;
      ts_err      <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      auto_q      <= auto_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      id_err      <= id_err_d;
      ts_err      <= ts_err_d;
      timeout_err <= tout_d;
      id_value    <= id_d;
      ts_value    <= ts_d;
    end
  end

  // Next-state and next-output logic; every output leaves this block through a register.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    read_d   = 1'b0;
    auto_d   = auto_q;
    busy_d   = 1'b0;
    done_d   = done;
    pass_d   = pass;
    id_err_d = id_err;
    ts_err_d = ts_err;
    tout_d   = timeout_err;
    id_d     = id_value;
    ts_d     = ts_value;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start || auto_q) begin
          state_d  = ST_RD_ID;
          auto_d   = 1'b0;
          addr_d   = ADDR_W'(SYSID_ID_OFS);
          read_d   = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          id_err_d = 1'b0;
          ts_err_d = 1'b0;
          tout_d   = 1'b0;
          tmr_clr  = 1'b1;
        end
      end

      ST_RD_ID, ST_RD_TS: begin
        read_d = 1'b1;
        busy_d = 1'b1;
        if (!avm.waitrequest) begin
          tmr_clr = 1'b1;
          if (state_q == ST_RD_ID) begin
            id_d    = avm.readdata;
            addr_d  = ADDR_W'(SYSID_TS_OFS);
            state_d = ST_RD_TS;
          end else begin
            ts_d    = avm.readdata;
            read_d  = 1'b0;
            state_d = ST_CHECK;
          end
        end else if (tmr_expire_c) begin
          // Fault path: abandon the read, keep whatever was already captured.
          read_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tout_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_CHECK: begin
        id_err_d = (id_value != EXPECTED_ID);
        ts_err_d = (ts_value != EXPECTED_TS);
        pass_d   = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Directed bench for soc_sysid_checker against a behavioural system-ID slave with programmable stalls.
module tb_soc_sysid_checker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy, done, pass, id_err, ts_err, timeout_err;
  logic [31:0] id_value, ts_value;

  logic [31:0] id_word, ts_word;
  int          stall_cfg, stall_left;
  logic        stuck;
  int          hold_viol;
  logic        prev_stall;
  logic        prev_addr;

  int n_cmp = 0;
  int n_bad = 0;

  soc_sysid_checker_if #(.ADDR_W(1)) avm ();

  soc_sysid_checker #(
    .ADDR_W      (1),
    .EXPECTED_ID (32'h0000_0000),
    .EXPECTED_TS (32'h635A_0997),
    .TIMEOUT     (4),
    .AUTO_START  (1'b1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .avm         (avm),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .id_err      (id_err),
    .ts_err      (ts_err),
    .timeout_err (timeout_err),
    .id_value    (id_value),
    .ts_value    (ts_value)
  );

  always #5 clock = ~clock;

  // Slave model: each read stalls stall_cfg cycles, or forever when stuck.
  assign avm.waitrequest = stuck | (avm.read && (stall_left != 0));
  assign avm.readdata    = (avm.address == 1'b0) ? id_word : ts_word;

  always @(posedge clock) begin
    if (!avm.read) stall_left <= stall_cfg;
    else if (stall_left != 0) stall_left <= stall_left - 1;
    else stall_left <= stall_cfg;
  end

  // Avalon hold rule: address must not move while a read is stalled.
  always @(negedge clock) begin
    if (reset_n && prev_stall && avm.read && (avm.address != prev_addr)) hold_viol = hold_viol + 1;
    prev_stall = avm.read && avm.waitrequest;
    prev_addr  = avm.address;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    stuck     = 1'b0;
    stall_cfg = 0;
    hold_viol = 0;
    prev_stall = 1'b0;
    prev_addr  = 1'b0;
    id_word   = 32'h0000_0000;
    ts_word   = 32'h635A_0997;

    // Reset values
    cyc(3);
    chk("rst_read", 32'(avm.read), 32'd0);
    chk("rst_addr", 32'(avm.address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_tout", 32'(timeout_err), 32'd0);
    chk("rst_id", id_value, 32'h0);
    chk("rst_ts", ts_value, 32'h0);

    // Auto start, zero-wait matching slave
    reset_n = 1'b1;
    cyc(1);
    chk("auto_c1_read", 32'(avm.read), 32'd1);
    chk("auto_c1_addr", 32'(avm.address), 32'd0);
    chk("auto_c1_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("auto_c2_addr", 32'(avm.address), 32'd1);
    chk("auto_c2_read", 32'(avm.read), 32'd1);
    cyc(1);
    chk("auto_c3_done", 32'(done), 32'd0);
    chk("auto_c3_read", 32'(avm.read), 32'd0);
    cyc(1);
    chk("auto_c4_done", 32'(done), 32'd1);
    chk("auto_c4_pass", 32'(pass), 32'd1);
    chk("auto_c4_errs", {29'd0, id_err, ts_err, timeout_err}, 32'd0);
    chk("auto_c4_busy", 32'(busy), 32'd0);
    chk("auto_c4_ts", ts_value, 32'h635A_0997);

    // Timestamp mismatch
    ts_word = 32'h635A_0998;
    pulse_start();
    cyc(3);
    chk("tsbad_done", 32'(done), 32'd1);
    chk("tsbad_pass", 32'(pass), 32'd0);
    chk("tsbad_ts_err", 32'(ts_err), 32'd1);
    chk("tsbad_id_err", 32'(id_err), 32'd0);
    chk("tsbad_ts", ts_value, 32'h635A_0998);

    // Three stall cycles on each read
    ts_word   = 32'h635A_0997;
    stall_cfg = 3;
    pulse_start();
    chk("stall_c1_cleared", {30'd0, done, ts_err}, 32'd0);
    chk("stall_c1_wait", 32'(avm.waitrequest), 32'd1);
    cyc(3);
    chk("stall_c4_addr", 32'(avm.address), 32'd0);
    cyc(1);
    chk("stall_c5_addr", 32'(avm.address), 32'd1);
    chk("stall_c5_read", 32'(avm.read), 32'd1);
    cyc(4);
    chk("stall_c9_done", 32'(done), 32'd0);
    cyc(1);
    chk("stall_c10_done", 32'(done), 32'd1);
    chk("stall_c10_pass", 32'(pass), 32'd1);
    chk("stall_hold", 32'(hold_viol), 32'd0);

    // Stuck waitrequest, TIMEOUT=4
    stall_cfg = 0;
    stuck     = 1'b1;
    pulse_start();
    cyc(3);
    chk("tout_c4_read", 32'(avm.read), 32'd1);
    chk("tout_c4_done", 32'(done), 32'd0);
    cyc(1);
    chk("tout_c5_read", 32'(avm.read), 32'd0);
    chk("tout_c5_done", 32'(done), 32'd1);
    chk("tout_c5_err", 32'(timeout_err), 32'd1);
    chk("tout_c5_pass", 32'(pass), 32'd0);
    chk("tout_c5_cmp", {30'd0, id_err, ts_err}, 32'd0);
    chk("tout_c5_busy", 32'(busy), 32'd0);
    chk("tout_ts_kept", ts_value, 32'h635A_0997);
    stuck = 1'b0;

    // Reset during RD_TS, then auto rerun
    pulse_start();
    cyc(1);
    chk("mrst_c2_addr", 32'(avm.address), 32'd1);
    chk("mrst_c2_read", 32'(avm.read), 32'd1);
    reset_n = 1'b0;
    cyc(1);
    chk("mrst_read", 32'(avm.read), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_flags", {27'd0, done, pass, id_err, ts_err, timeout_err}, 32'd0);
    chk("mrst_ts", ts_value, 32'h0);
    reset_n = 1'b1;
    cyc(4);
    chk("mrst_rerun_done", 32'(done), 32'd1);
    chk("mrst_rerun_pass", 32'(pass), 32'd1);

    // start while busy is dropped; start in DONE reruns
    pulse_start();
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    chk("busy_start_done", 32'(done), 32'd1);
    chk("busy_start_pass", 32'(pass), 32'd1);
    cyc(2);
    chk("busy_start_idle", 32'(busy), 32'd0);
    chk("busy_start_read", 32'(avm.read), 32'd0);
    ts_word = 32'h635A_0998;
    pulse_start();
    chk("rerun_c1_cleared", {30'd0, done, pass}, 32'd0);
    chk("rerun_c1_read", 32'(avm.read), 32'd1);
    chk("rerun_c1_addr", 32'(avm.address), 32'd0);
    cyc(3);
    chk("rerun_done", 32'(done), 32'd1);
    chk("rerun_ts_err", 32'(ts_err), 32'd1);
    chk("rerun_ts", ts_value, 32'h635A_0998);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/soc_sysid_checker.md
# soc_sysid_checker

Avalon-MM read master that interrogates the SoC system-ID slave after reset (or on request), fetches the ID word (offset 0) and the timestamp word (offset 1), compares both against build-time expected values, and publishes a sticky pass/fail status. It sits beside the RV32IM core on the SoC interconnect as a boot-integrity check. Firmware or the board LEDs use its status to confirm the bitstream matches the software build.

## Interface
Parameters:
- ADDR_W, 1: master address width, in word addresses.
- EXPECTED_ID, 32'h0000_0000: required value at offset 0.
- EXPECTED_TS, 32'h635A_0997: required value at offset 1. This is 1666845079 decimal.
- TIMEOUT, 255: maximum waitrequest cycles per read before the check aborts. Legal range is 1..65535.
- AUTO_START, 1: when 1, a check runs automatically after reset deasserts.

Ports:
- clock, in, 1: single clock.
- reset_n, in, 1: reset, synchronous and active-low. It is sampled on the rising edge of clock.
- start, in, 1: one-cycle pulse that requests a new check. Ignored unless the block is in IDLE or DONE.
- avm_address, out, ADDR_W: word address of the current read.
- avm_read, out, 1: read request.
- avm_waitrequest, in, 1: slave stall.
- avm_readdata, in, 32: read data. Valid in the cycle where avm_read=1 and avm_waitrequest=0.
- busy, out, 1: a check is in progress.
- done, out, 1: sticky. Set when a check finishes.
- pass, out, 1: sticky. Set when both words match and no timeout occurred.
- id_err, out, 1: ID word mismatch.
- ts_err, out, 1: timestamp word mismatch.
- timeout_err, out, 1: a read exceeded TIMEOUT stall cycles.
- id_value, out, 32: captured ID word.
- ts_value, out, 32: captured timestamp word.

## Operation
- States are IDLE, RD_ID, RD_TS, CHECK and DONE.
- Reset values:
  - State is IDLE.
  - All 1-bit outputs are 0.
  - avm_address = 0.
  - id_value and ts_value = 0.
  - Wait counter = 0.
- IDLE:
  - Moves to RD_ID if start=1, or on the first cycle after reset when AUTO_START=1.
  - On entry to RD_ID, the wait counter clears and done, pass, id_err, ts_err and timeout_err all clear.
- RD_ID:
  - Drives avm_read=1, avm_address=0 and busy=1.
  - If avm_waitrequest=0, it captures avm_readdata into id_value and moves to RD_TS. avm_address becomes 1 and the counter clears.
  - If avm_waitrequest=1, the counter increments. When the counter reaches TIMEOUT with the stall still present, the block sets timeout_err and goes to DONE.
- RD_TS: same behaviour as RD_ID at address 1, capturing into ts_value. On acceptance it moves to CHECK.
- CHECK (one cycle, avm_read=0):
  - id_err = (id_value != EXPECTED_ID).
  - ts_err = (ts_value != EXPECTED_TS).
  - pass = ~(id_err | ts_err).
  - Then moves to DONE.
- DONE:
  - done=1, busy=0, avm_read=0.
  - Status holds until the next start.
  - start in DONE behaves exactly as start in IDLE.
- avm_address and avm_read are registered outputs, changing only on clock edges.
  - avm_address holds stable while avm_read=1 and avm_waitrequest=1. This is the Avalon hold rule.
  - The only exception is the timeout abort, which is a fault path only.
- start while busy is ignored and not queued.
- On a timeout, pass=0 and id_err/ts_err remain 0. Any word already captured stays visible.

## Timing
- Zero-wait-state slave: start is sampled at edge 0.
  - avm_read=1 at address 0 during cycle 1.
  - Address 1 during cycle 2.
  - CHECK in cycle 3.
  - done=1 from cycle 4.
  - Total latency from start to done is 4 cycles.
- Each waitrequest cycle adds one cycle to latency.
- Timeout: after TIMEOUT consecutive stalled cycles in one read state, avm_read falls and done/timeout_err rise on the following edge.
- The counter is 16 bits, saturating, and clears on each accepted read.
- Reset mid-read (reset_n=0 at any edge): avm_read falls at that same edge. All outputs return to reset values and there is no partial status. With AUTO_START=1, the check restarts once reset releases.
- start coincident with reset_n=0 is ignored.

## Structure
- Package soc_sysid_pkg holds:
  - the state enum;
  - SYSID_ID_OFS = 0 and SYSID_TS_OFS = 1;
  - the default expected-value constants, shared with the system-ID slave generator.
- One natural sub-module, soc_wait_timer: a saturating counter with clear, enable, and a terminal-count compare against TIMEOUT.
- Everything else is a single FSM process plus capture registers.

## Test plan
- Matching zero-wait slave (0x0000_0000 / 0x635A_0997), AUTO_START=1 -> reads addresses 0 then 1; done=1 and pass=1 at cycle 4 after reset release; no error flags.
- Slave returns ts=0x635A_0998 -> done=1, pass=0, ts_err=1, id_err=0, ts_value=0x635A_0998.
- waitrequest held for 3 cycles on each read -> address held stable throughout; pass=1 with done at cycle 10.
- waitrequest stuck high with TIMEOUT=4 -> timeout_err=1, done=1, pass=0; avm_read=0 from the cycle after the 4th stall.
- reset_n=0 during RD_TS, then released -> all outputs 0 at that edge; the check reruns and passes.
- start pulsed while busy, then pulsed again in DONE -> first pulse ignored; second pulse clears status and repeats the full read sequence.
